bus_mux_reg: RTL and testbench



---
 rtl/bus_mux_reg.sv | 133 +++++++++++++
 tb/tb_bus_mux_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer: R_i / G / DIN onto a held bus with sticky collision flag.
// Define BUSMUX_ERRCNT_EN to build the saturating collision-cycle counter on ErrCnt.
module bus_mux_reg #(
  parameter int W     = 16,
  parameter int NREG  = 8,
  parameter int SRC_W = 4
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [W-1:0]        DIN,
  input  logic [W-1:0]        G,
  input  logic [NREG*W-1:0]   R_flat,
  input  logic [NREG-1:0]     ROut,
  input  logic                GOut,
  input  logic                DINOut,
  input  logic                ErrClr,
  output logic [W-1:0]        BusWires,
  output logic                BusValid,
  output logic [SRC_W-1:0]    SrcId,
  output logic                SelErr,
  output logic [7:0]          ErrCnt
);

  localparam int NSRC = NREG + 2;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [NSRC-1:0] v);
    return |(v & (v - NSRC'(1)));
  endfunction

  logic [NSRC-1:0]   en_all_s;
  logic              coll_s;
  logic              sel_s;
  logic [W-1:0]      data_s;
  logic [SRC_W-1:0]  src_s;
  logic [SRC_W-1:0]  ridx_s;

  assign en_all_s = {DINOut, GOut, ROut};
  assign coll_s   = multi_hot(en_all_s);

  // Lowest-index set ROut bit; scanning downward lets the lowest index overwrite.
  always_comb begin
    ridx_s = {SRC_W{1'b0}};
    for (int i = NREG - 1; i >= 0; i--) begin
      if (ROut[i]) begin
        ridx_s = SRC_W'(i);
      end else begin
        ridx_s = ridx_s;
      end
    end
  end

  // Source priority: DIN over G over registers.
  always_comb begin
    sel_s  = 1'b0;
    data_s = {W{1'b0}};
    src_s  = {SRC_W{1'b0}};
    if (DINOut) begin
      sel_s  = 1'b1;
      data_s = DIN;
      src_s  = SRC_W'(NREG + 1);
    end else if (GOut) begin
      sel_s  = 1'b1;
      data_s = G;
      src_s  = SRC_W'(NREG);
    end else if (|ROut) begin
      sel_s  = 1'b1;
      data_s = R_flat[ridx_s*W +: W];
      src_s  = ridx_s;
    end else begin
      sel_s  = 1'b0;
    end
  end

  // Bus register: load on a selection, otherwise hold data and source.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      BusWires <= {W{1'b0}};
      SrcId    <= {SRC_W{1'b0}};
      BusValid <= 1'b0;
    end else begin
      BusValid <= sel_s;
      if (sel_s) begin
        BusWires <= data_s;
        SrcId    <= src_s;
      end else begin
        BusWires <= BusWires;
        SrcId    <= SrcId;
      end
    end
  end

  // Sticky collision flag; a collision on the clearing edge wins.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SelErr <= 1'b0;
    end else if (coll_s) begin
      SelErr <= 1'b1;
    end else if (ErrClr) begin
      SelErr <= 1'b0;
    end else begin
      SelErr <= SelErr;
    end
  end

`ifdef BUSMUX_ERRCNT_EN
  logic [7:0] errcnt_r;

  // Saturating collision counter; clear with a same-edge collision lands on 1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      errcnt_r <= 8'd0;
    end else if (coll_s) begin
      if (ErrClr) begin
        errcnt_r <= 8'd1;
      end else if (errcnt_r != 8'hFF) begin
        errcnt_r <= errcnt_r + 8'd1;
      end else begin
        errcnt_r <= errcnt_r;
      end
    end else if (ErrClr) begin
      errcnt_r <= 8'd0;
    end else begin
      errcnt_r <= errcnt_r;
    end
  end

  assign ErrCnt = errcnt_r;
`else
  assign ErrCnt = 8'd0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg; expected ErrCnt follows BUSMUX_ERRCNT_EN.
module tb_bus_mux_reg;

  localparam int W     = 16;
  localparam int NREG  = 8;
  localparam int SRC_W = 4;

  logic              Clock;
  logic              Resetn;
  logic [W-1:0]      DIN;
  logic [W-1:0]      G;
  logic [NREG*W-1:0] R_flat;
  logic [NREG-1:0]   ROut;
  logic              GOut;
  logic              DINOut;
  logic              ErrClr;
  logic [W-1:0]      BusWires;
  logic              BusValid;
  logic [SRC_W-1:0]  SrcId;
  logic              SelErr;
  logic [7:0]        ErrCnt;

  int checks;
  int failures;
  int exp_cnt;

  bus_mux_reg #(.W(W), .NREG(NREG), .SRC_W(SRC_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .G(G), .R_flat(R_flat),
    .ROut(ROut), .GOut(GOut), .DINOut(DINOut), .ErrClr(ErrClr),
    .BusWires(BusWires), .BusValid(BusValid), .SrcId(SrcId),
    .SelErr(SelErr), .ErrCnt(ErrCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    ROut = 8'd0; GOut = 1'b0; DINOut = 1'b0; ErrClr = 1'b0;
  endtask

  // Collision counter model: count, saturate, clear (set wins).
  task automatic cnt_model(input bit coll, input bit clr);
`ifdef BUSMUX_ERRCNT_EN
    if (coll) exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
    else if (clr) exp_cnt = 0;
`else
    exp_cnt = 0;
`endif
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    Resetn = 1'b0;
    DIN = W'($urandom); G = W'($urandom);
    R_flat = {$urandom, $urandom, $urandom, $urandom};
    ROut = NREG'($urandom); GOut = 1'b1; DINOut = 1'b1; ErrClr = 1'b0;
    repeat (3) step();
    check("rst_bus", 32'(BusWires), 32'h0);
    check("rst_valid", 32'(BusValid), 32'h0);
    check("rst_src", 32'(SrcId), 32'h0);
    check("rst_err", 32'(SelErr), 32'h0);
    check("rst_cnt", 32'(ErrCnt), 32'h0);

    Resetn = 1'b1;
    idle();
    DIN = 16'h00A5; DINOut = 1'b1;
    for (int i = 0; i < NREG; i++) R_flat[i*W +: W] = 16'h1000 + 16'(i);
    step();
    check("din_bus", 32'(BusWires), 32'h00A5);
    check("din_src", 32'(SrcId), 32'd9);
    check("din_valid", 32'(BusValid), 32'h1);
    check("din_err", 32'(SelErr), 32'h0);

    for (int i = 0; i < NREG; i++) begin
      idle();
      ROut = NREG'(1) << i;
      step();
      check("sweep_bus", 32'(BusWires), 32'h1000 + 32'(i));
      check("sweep_src", 32'(SrcId), 32'(i));
      check("sweep_valid", 32'(BusValid), 32'h1);
    end
    idle();
    step();
    check("hold_bus", 32'(BusWires), 32'h1007);
    check("hold_src", 32'(SrcId), 32'd7);
    check("hold_valid", 32'(BusValid), 32'h0);
    check("idle_noerr", 32'(SelErr), 32'h0);

    ROut = 8'b00000100; GOut = 1'b1; G = 16'hBEEF;
    step(); cnt_model(1'b1, 1'b0);
    check("pri_bus", 32'(BusWires), 32'hBEEF);
    check("pri_src", 32'(SrcId), 32'd8);
    check("pri_err", 32'(SelErr), 32'h1);
    check("pri_cnt", 32'(ErrCnt), 32'(exp_cnt));
    idle();
    ROut = 8'b00100100;
    step(); cnt_model(1'b1, 1'b0);
    check("low_bus", 32'(BusWires), 32'h1002);
    check("low_src", 32'(SrcId), 32'd2);
    check("low_cnt", 32'(ErrCnt), 32'(exp_cnt));

    idle();
    repeat (5) step();
    check("sticky_err", 32'(SelErr), 32'h1);
    check("sticky_valid", 32'(BusValid), 32'h0);
    ErrClr = 1'b1;
    step(); cnt_model(1'b0, 1'b1);
    check("clr_err", 32'(SelErr), 32'h0);
    check("clr_cnt", 32'(ErrCnt), 32'(exp_cnt));
    DINOut = 1'b1; GOut = 1'b1;
    step(); cnt_model(1'b1, 1'b1);
    check("clrset_err", 32'(SelErr), 32'h1);
    check("clrset_cnt", 32'(ErrCnt), 32'(exp_cnt));
    check("clrset_bus", 32'(BusWires), 32'h00A5);
    check("clrset_src", 32'(SrcId), 32'd9);

    ErrClr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step(); cnt_model(1'b1, 1'b0);
      if (n == 100) check("cnt_mid", 32'(ErrCnt), 32'(exp_cnt));
    end
    check("cnt_sat", 32'(ErrCnt), 32'(exp_cnt));
    idle(); ErrClr = 1'b1;
    step(); cnt_model(1'b0, 1'b1);
    check("cnt_clr", 32'(ErrCnt), 32'(exp_cnt));
    check("cnt_clr_err", 32'(SelErr), 32'h0);

    idle();
    GOut = 1'b1; ROut = 8'b00000001; G = 16'hBEEF;
    step();
    check("pre_rst_bus", 32'(BusWires), 32'hBEEF);
    check("pre_rst_err", 32'(SelErr), 32'h1);
    #2 Resetn = 1'b0;
    #1;
    check("arst_bus", 32'(BusWires), 32'h0);
    check("arst_valid", 32'(BusValid), 32'h0);
    check("arst_src", 32'(SrcId), 32'h0);
    check("arst_err", 32'(SelErr), 32'h0);
    check("arst_cnt", 32'(ErrCnt), 32'h0);
    step();
    Resetn = 1'b1;
    idle();
    step();
    check("post_rst_bus", 32'(BusWires), 32'h0);
    check("post_rst_valid", 32'(BusValid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
